// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle for the bit-serial adder controller.
// The sub line exists only when SERIAL_ADD_SUB_EN is defined.
`timescale 1ns/1ps
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder stepped LSB-first over WIDTH bits.
// Optional macro SERIAL_ADD_SUB_EN adds a subtract mode (b inverted, carry-in forced to 1).
`timescale 1ns/1ps
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH-1 shifts the partial
  // result fills res_sr, so the final bit completes the word.
  assign res_nxt = {fa_s, res_sr};

  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
    if (bus.sub) begin
      b_load = ~bus.b;
      c_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= b_load;
            carry  <= c_load;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          res_sr <= res_nxt[WIDTH-1:1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_q  <= res_nxt;
            cout_q <= fa_co;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8); subtract cases run when SERIAL_ADD_SUB_EN is defined.
`timescale 1ns/1ps
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();
  serial_add_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  logic [WIDTH:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub);
    logic [WIDTH:0]   e;
    logic [WIDTH-1:0] nb;
    nb = ~b;
    if (sub && SUB_EN) e = {1'b0, a} + {1'b0, nb} + (WIDTH+1)'(1);
    else               e = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    sb.push_back(e);
    bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sub;
`endif
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4*WIDTH) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [WIDTH:0] pop_exp();
    logic [WIDTH:0] e;
    e = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'($urandom); bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
      bus.cin = 1'($urandom);
      tick();
    end
    vectors++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: busy=%b done=%b cout=%b sum=%h, want all 0",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b done=%b cout=%b sum=%h, want all 0",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
  endtask

  task automatic test_basic_add();
    int cyc;
    logic [WIDTH:0] e;
    drive_start(8'h2D, 8'h1F, 1'b0, 1'b0);
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_accept: busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    wait_done(cyc);
    vectors++;
    if (cyc !== WIDTH) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d edges, want %0d", cyc, WIDTH);
    end
    e = pop_exp();
    vectors++;
    if ({bus.cout, bus.sum} !== e || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: cout=%b sum=%h busy=%b, want cout=%b sum=%h busy=0",
               bus.cout, bus.sum, bus.busy, e[WIDTH], e[WIDTH-1:0]);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 8'h4C) begin
      miscompares++;
      $display("FAIL basic_idle: done=%b busy=%b sum=%h, want 0 0 4c", bus.done, bus.busy, bus.sum);
    end
  endtask

  task automatic test_carry_wrap();
    int cyc;
    logic [WIDTH:0] e;
    drive_start(8'hFF, 8'h01, 1'b1, 1'b0);
    wait_done(cyc);
    e = pop_exp();
    vectors++;
    if ({bus.cout, bus.sum} !== e || cyc !== WIDTH) begin
      miscompares++;
      $display("FAIL wrap_ff_01: cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d",
               bus.cout, bus.sum, cyc, e[WIDTH], e[WIDTH-1:0], WIDTH);
    end
    tick();
    drive_start(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(cyc);
    e = pop_exp();
    vectors++;
    if ({bus.cout, bus.sum} !== e || cyc !== WIDTH) begin
      miscompares++;
      $display("FAIL wrap_ff_ff: cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d",
               bus.cout, bus.sum, cyc, e[WIDTH], e[WIDTH-1:0], WIDTH);
    end
    tick();
  endtask

  // Leaves the bench sitting in the done cycle for test_back_to_back.
  task automatic test_ignored_start();
    int cyc;
    logic [WIDTH:0] e;
    drive_start(8'h10, 8'h20, 1'b0, 1'b0);
    tick(); tick(); tick();
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(cyc);
    e = pop_exp();
    vectors++;
    if ({bus.cout, bus.sum} !== e || cyc + 4 !== WIDTH) begin
      miscompares++;
      $display("FAIL ignored_start: cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d",
               bus.cout, bus.sum, cyc + 4, e[WIDTH], e[WIDTH-1:0], WIDTH);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [WIDTH:0] e;
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_in_done: done=%b, want 1", bus.done);
    end
    drive_start(8'h01, 8'h02, 1'b0, 1'b0);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.sum !== 8'h30) begin
      miscompares++;
      $display("FAIL b2b_accept: done=%b busy=%b sum=%h, want 0 1 30", bus.done, bus.busy, bus.sum);
    end
    tick(); tick(); tick();
    vectors++;
    if (bus.sum !== 8'h30 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold: sum=%h done=%b, want 30 0", bus.sum, bus.done);
    end
    wait_done(cyc);
    e = pop_exp();
    vectors++;
    if ({bus.cout, bus.sum} !== e || cyc + 3 !== WIDTH) begin
      miscompares++;
      $display("FAIL b2b_result: cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d",
               bus.cout, bus.sum, cyc + 3, e[WIDTH], e[WIDTH-1:0], WIDTH);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int seen;
    logic [WIDTH:0] e;
    drive_start(8'h33, 8'h44, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    sb.delete();
    vectors++;
    if ({bus.busy, bus.done, bus.cout, bus.sum} !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs: busy=%b done=%b cout=%b sum=%h, want all 0",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0 || bus.sum !== '0) begin
      miscompares++;
      $display("FAIL midrst_no_done: done pulses=%0d sum=%h, want 0 00", seen, bus.sum);
    end
    drive_start(8'h05, 8'h07, 1'b0, 1'b0);
    wait_done(cyc);
    e = pop_exp();
    vectors++;
    if ({bus.cout, bus.sum} !== e || cyc !== WIDTH) begin
      miscompares++;
      $display("FAIL midrst_after: cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d",
               bus.cout, bus.sum, cyc, e[WIDTH], e[WIDTH-1:0], WIDTH);
    end
    tick();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int cyc;
    logic [WIDTH:0] e;
    drive_start(8'h10, 8'h03, 1'b0, 1'b1);
    wait_done(cyc);
    e = pop_exp();
    vectors++;
    if ({bus.cout, bus.sum} !== e || {bus.cout, bus.sum} !== 9'h10D) begin
      miscompares++;
      $display("FAIL sub_no_borrow: cout=%b sum=%h, want cout=1 sum=0d", bus.cout, bus.sum);
    end
    tick();
    drive_start(8'h03, 8'h10, 1'b1, 1'b1);
    wait_done(cyc);
    e = pop_exp();
    vectors++;
    if ({bus.cout, bus.sum} !== e || {bus.cout, bus.sum} !== 9'h0F3) begin
      miscompares++;
      $display("FAIL sub_borrow: cout=%b sum=%h, want cout=0 sum=f3", bus.cout, bus.sum);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    int cyc;
    logic [WIDTH:0] e;
    for (int i = 0; i < 10; i++) begin
      drive_start(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      wait_done(cyc);
      e = pop_exp();
      vectors++;
      if ({bus.cout, bus.sum} !== e || cyc !== WIDTH) begin
        miscompares++;
        $display("FAIL random_%0d: cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=%0d",
                 i, bus.cout, bus.sum, cyc, e[WIDTH], e[WIDTH-1:0], WIDTH);
      end
      if ($urandom_range(1, 0) == 1) tick();
    end
    tick();
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    test_reset();
    test_basic_add();
    test_carry_wrap();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
